// File: rtl/tabla_axi_ctrl_slave_pkg.sv
// Shared definitions for the Tabla AXI4-Lite control slave: register map,
// identification constant and response codes.
package tabla_axi_pkg;

  typedef enum logic [3:0] {
    REG_CTRL         = 4'd0,
    REG_TX_DONE      = 4'd1,
    REG_RD_DONE      = 4'd2,
    REG_WR_DONE      = 4'd3,
    REG_TOTAL_CYCLES = 4'd4,
    REG_RD_CYCLES    = 4'd5,
    REG_PR_CYCLES    = 4'd6,
    REG_WR_CYCLES    = 4'd7,
    REG_PROC_DONE    = 4'd8,
    REG_ID           = 4'd15
  } reg_idx_e;

  localparam logic [31:0] TABLA_ID  = 32'h7AB1_A001;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/tabla_axi_ctrl_slave_if.sv
// AXI4-Lite bundle between the host master and the Tabla control slave.
interface tabla_axi_ctrl_slave_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/tabla_axi_ctrl_slave.sv
// AXI4-Lite register block: host-writable CTRL with start pulse, read-only
// status flags, performance counters and an ID word.
module tabla_axi_ctrl_slave
  import tabla_axi_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_ADDR_WIDTH = 6,
  parameter int PERF_CNTR_WIDTH = 32
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  tabla_axi_ctrl_slave_if.slave      s_axi,
  output logic                       tx_req,
  output logic [AXIS_DATA_WIDTH-1:0] ctrl_reg,
  input  logic                       tx_done,
  input  logic                       rd_done,
  input  logic                       wr_done,
  input  logic                       processing_done,
  input  logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  input  logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);

  localparam int IDX_W  = AXIS_ADDR_WIDTH - 2;
  localparam int STRB_W = AXIS_DATA_WIDTH / 8;

  logic                       rst_hold_q;
  logic                       aw_full_q;
  logic [IDX_W-1:0]           aw_idx_q;
  logic                       w_full_q;
  logic [AXIS_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]          w_strb_q;
  logic                       bvalid_q;
  logic [AXIS_DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                       tx_req_q, tx_req_d;
  logic                       rvalid_q;
  logic [AXIS_DATA_WIDTH-1:0] rdata_q, rd_mux;

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs, wr_exec, ctrl_wr;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_bits;

  // Keeps all READYs low through reset and the first edge after release.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) rst_hold_q <= 1'b1;
    else              rst_hold_q <= 1'b0;
  end

  assign awready = ~aw_full_q & ~bvalid_q & ~rst_hold_q;
  assign wready  = ~w_full_q & ~bvalid_q & ~rst_hold_q;
  assign arready = ~rvalid_q & ~rst_hold_q;

  assign aw_hs   = s_axi.S_AXI_AWVALID & awready;
  assign w_hs    = s_axi.S_AXI_WVALID & wready;
  assign ar_hs   = s_axi.S_AXI_ARVALID & arready;
  assign wr_exec = aw_full_q & w_full_q & ~bvalid_q;
  assign ctrl_wr = wr_exec & (aw_idx_q == IDX_W'(REG_CTRL));
  assign ar_idx  = s_axi.S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2];

  always_comb begin
    ctrl_d = ctrl_q;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (w_strb_q[b]) ctrl_d[8*b +: 8] = w_data_q[8*b +: 8];
    end
    tx_req_d = ctrl_wr & w_strb_q[0] & w_data_q[0];
  end

  // Write channel: AW and W park independently; the write fires once both
  // are parked and no response is outstanding.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      ctrl_q    <= '0;
      tx_req_q  <= 1'b0;
    end else begin
      tx_req_q <= tx_req_d;
      if (ctrl_wr) ctrl_q <= ctrl_d;
      if (wr_exec) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= s_axi.S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_data_q <= s_axi.S_AXI_WDATA;
          w_strb_q <= s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q & s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      IDX_W'(REG_CTRL):         rd_mux = ctrl_q;
      IDX_W'(REG_TX_DONE):      rd_mux[0] = tx_done;
      IDX_W'(REG_RD_DONE):      rd_mux[0] = rd_done;
      IDX_W'(REG_WR_DONE):      rd_mux[0] = wr_done;
      IDX_W'(REG_TOTAL_CYCLES): rd_mux[PERF_CNTR_WIDTH-1:0] = total_cycles;
      IDX_W'(REG_RD_CYCLES):    rd_mux[PERF_CNTR_WIDTH-1:0] = rd_cycles;
      IDX_W'(REG_PR_CYCLES):    rd_mux[PERF_CNTR_WIDTH-1:0] = pr_cycles;
      IDX_W'(REG_WR_CYCLES):    rd_mux[PERF_CNTR_WIDTH-1:0] = wr_cycles;
      IDX_W'(REG_PROC_DONE):    rd_mux[0] = processing_done;
      IDX_W'(REG_ID):           rd_mux = TABLA_ID;
      default:                  rd_mux = '0;
    endcase
  end

  // Read channel: data is snapshotted at the AR handshake and held until taken.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q & s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign tx_req              = tx_req_q;
  assign ctrl_reg            = ctrl_q;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_tabla_axi_ctrl_slave.sv
// Self-checking bench for tabla_axi_ctrl_slave against a register-map model.
module tb_tabla_axi_ctrl_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tabla_axi_ctrl_slave_if #(.ADDR_W(6), .DATA_W(32)) bus();

  logic        tx_req;
  logic [31:0] ctrl_reg;
  logic        tx_done = 1'b0, rd_done = 1'b0, wr_done = 1'b0, processing_done = 1'b0;
  logic [31:0] total_cycles = '0, rd_cycles = '0, pr_cycles = '0, wr_cycles = '0;

  tabla_axi_ctrl_slave #(
    .AXIS_DATA_WIDTH(32),
    .AXIS_ADDR_WIDTH(6),
    .PERF_CNTR_WIDTH(32)
  ) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESET    (rst),
    .s_axi           (bus),
    .tx_req          (tx_req),
    .ctrl_reg        (ctrl_reg),
    .tx_done         (tx_done),
    .rd_done         (rd_done),
    .wr_done         (wr_done),
    .processing_done (processing_done),
    .total_cycles    (total_cycles),
    .rd_cycles       (rd_cycles),
    .pr_cycles       (pr_cycles),
    .wr_cycles       (wr_cycles)
  );

  int tests = 0;
  int fails = 0;
  int tx_cnt = 0;
  int tx_exp = 0;
  logic [31:0] ctrl_m = '0;

  always @(negedge clk) if (tx_req === 1'b1) tx_cnt++;

  typedef struct {
    int lat; logic [1:0] resp; logic tx_at_b; int early_b; int held; logic b_after;
  } wr_res_t;
  typedef struct {
    bit ok; logic valid_now; logic [31:0] data; logic [1:0] resp; int stable; logic r_after;
  } rd_res_t;

  function automatic logic [31:0] exp_read(input logic [5:0] addr);
    case (int'(addr) / 4)
      0:       return ctrl_m;
      1:       return {31'b0, tx_done};
      2:       return {31'b0, rd_done};
      3:       return {31'b0, wr_done};
      4:       return total_cycles;
      5:       return rd_cycles;
      6:       return pr_cycles;
      7:       return wr_cycles;
      8:       return {31'b0, processing_done};
      15:      return 32'h7AB1_A001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [5:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (int'(addr) / 4 != 0) return;
    for (int b = 0; b < 4; b++) if (strb[b]) ctrl_m[8*b +: 8] = data[8*b +: 8];
    if (strb[0] && data[0]) tx_exp++;
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input int b_delay, output wr_res_t r);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    r.lat = -1; r.resp = 'x; r.tx_at_b = 1'b0; r.early_b = 0; r.held = 0; r.b_after = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWPROT  = 3'($urandom);
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = (w_delay == 0);
    while (!(aw_done && w_done) && n < 100) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1; n++;
      if (aw_hs) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.S_AXI_WVALID = 1'b0; end
      if (!w_done && n >= w_delay) bus.S_AXI_WVALID = 1'b1;
      if (!(aw_done && w_done) && bus.S_AXI_BVALID === 1'b1) r.early_b++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) return;
    n = 0;
    while (bus.S_AXI_BVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.S_AXI_BVALID !== 1'b1) return;
    r.lat = n; r.resp = bus.S_AXI_BRESP; r.tx_at_b = tx_req;
    for (int i = 0; i < b_delay; i++) begin
      @(posedge clk); #1;
      if (bus.S_AXI_BVALID === 1'b1) r.held++;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    r.b_after = bus.S_AXI_BVALID;
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_delay, input bit perturb,
                          output rd_res_t r);
    bit hs;
    int n;
    r.ok = 0; r.valid_now = 1'b0; r.data = 'x; r.resp = 'x; r.stable = 0; r.r_after = 1'b1;
    n = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARPROT  = 3'($urandom);
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b1;
    while (!r.ok && n < 100) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge clk); #1; n++;
      if (hs) r.ok = 1;
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!r.ok) return;
    r.valid_now = bus.S_AXI_RVALID; r.data = bus.S_AXI_RDATA; r.resp = bus.S_AXI_RRESP;
    for (int i = 0; i < r_delay; i++) begin
      if (perturb) total_cycles = $urandom;
      @(posedge clk); #1;
      if (bus.S_AXI_RVALID === 1'b1 && bus.S_AXI_RDATA === r.data) r.stable++;
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    r.r_after = bus.S_AXI_RVALID;
  endtask

  task automatic test_reset();
    bit rdy_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if ((bus.S_AXI_AWREADY | bus.S_AXI_WREADY | bus.S_AXI_ARREADY) !== 1'b0) rdy_seen = 1;
    end
    tests++;
    if (rdy_seen) begin fails++; $display("FAIL reset_ready_low: READY seen high during reset, required 0"); end
    tests++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, tx_req} !== 7'b0 ||
        bus.S_AXI_RDATA !== 32'h0 || ctrl_reg !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: bv=%b rv=%b rdata=%h ctrl=%h tx=%b, required all 0",
               bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA, ctrl_reg, tx_req);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
      fails++;
      $display("FAIL ready_after_release: got %b, required 000",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      fails++;
      $display("FAIL ready_first_edge: got %b, required 111",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
  endtask

  task automatic test_write_read();
    wr_res_t w;
    rd_res_t r;
    axi_write(6'h00, 32'hDEAD_BEEF, 4'hF, 0, 3, w);
    model_write(6'h00, 32'hDEAD_BEEF, 4'hF);
    tests++;
    if (w.lat !== 1) begin fails++; $display("FAIL wr_latency: got %0d, required 1", w.lat); end
    tests++;
    if (w.held !== 3 || w.b_after !== 1'b0) begin
      fails++; $display("FAIL bvalid_hold: held %0d after %b, required 3 then 0", w.held, w.b_after);
    end
    tests++;
    if (w.resp !== 2'b00) begin fails++; $display("FAIL bresp: got %b, required 00", w.resp); end
    axi_read(6'h00, 0, 0, r);
    tests++;
    if (!r.ok || r.valid_now !== 1'b1 || r.data !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL read_ctrl: got %h (rvalid %b), required deadbeef", r.data, r.valid_now);
    end
    tests++;
    if (r.resp !== 2'b00 || r.r_after !== 1'b0) begin
      fails++; $display("FAIL rresp_clear: resp %b rvalid_after %b, required 00/0", r.resp, r.r_after);
    end
  endtask

  task automatic test_tx_req();
    wr_res_t w;
    int base;
    base = tx_cnt;
    axi_write(6'h00, 32'h0000_0001, 4'hF, 0, 0, w);
    model_write(6'h00, 32'h0000_0001, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (w.tx_at_b !== 1'b1 || tx_cnt - base !== 1) begin
      fails++; $display("FAIL tx_pulse: at_b %b count %0d, required 1 and 1", w.tx_at_b, tx_cnt - base);
    end
    base = tx_cnt;
    axi_write(6'h00, 32'hCAFE_BAFF, 4'b1110, 0, 0, w);
    model_write(6'h00, 32'hCAFE_BAFF, 4'b1110);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ctrl_reg !== ctrl_m || ctrl_reg[7:0] !== 8'h01) begin
      fails++; $display("FAIL strobe_ctrl: got %h, required %h", ctrl_reg, ctrl_m);
    end
    tests++;
    if (tx_cnt - base !== 0) begin fails++; $display("FAIL tx_no_pulse: got %0d pulses, required 0", tx_cnt - base); end
  endtask

  task automatic test_aw_before_w();
    wr_res_t w;
    axi_write(6'h00, 32'h1234_5670, 4'hF, 4, 0, w);
    model_write(6'h00, 32'h1234_5670, 4'hF);
    tests++;
    if (w.early_b !== 0 || w.lat !== 1) begin
      fails++; $display("FAIL aw_before_w: early %0d lat %0d, required 0 and 1", w.early_b, w.lat);
    end
    tests++;
    if (ctrl_reg !== ctrl_m) begin fails++; $display("FAIL aw_before_w_ctrl: got %h, required %h", ctrl_reg, ctrl_m); end
  endtask

  task automatic test_status_regs();
    rd_res_t r;
    logic [5:0] addrs [6];
    logic [31:0] exp;
    addrs = '{6'h04, 6'h10, 6'h3C, 6'h28, 6'h13, 6'h20};
    tx_done = 1'b1;
    total_cycles = 32'h1234_5678;
    rd_cycles = $urandom; pr_cycles = $urandom; wr_cycles = $urandom;
    processing_done = 1'b1;
    foreach (addrs[i]) begin
      exp = exp_read(addrs[i]);
      axi_read(addrs[i], 0, 0, r);
      tests++;
      if (!r.ok || r.data !== exp) begin
        fails++; $display("FAIL status_read_%h: got %h, required %h", addrs[i], r.data, exp);
      end
    end
  endtask

  task automatic test_read_stall();
    rd_res_t r;
    logic [31:0] exp;
    total_cycles = 32'hA5A5_0001;
    exp = exp_read(6'h10);
    axi_read(6'h10, 5, 1, r);
    tests++;
    if (r.data !== exp || r.stable !== 5 || r.r_after !== 1'b0) begin
      fails++; $display("FAIL read_stall: data %h stable %0d after %b, required %h/5/0",
                        r.data, r.stable, r.r_after, exp);
    end
  endtask

  task automatic test_ro_write();
    wr_res_t w;
    rd_res_t r;
    logic [31:0] exp;
    axi_write(6'h10, 32'h0000_0055, 4'hF, 0, 0, w);
    model_write(6'h10, 32'h0000_0055, 4'hF);
    total_cycles = 32'h0BAD_F00D;
    exp = exp_read(6'h10);
    axi_read(6'h10, 0, 0, r);
    tests++;
    if (w.resp !== 2'b00 || r.data !== exp) begin
      fails++; $display("FAIL ro_write: resp %b data %h, required 00/%h", w.resp, r.data, exp);
    end
    tests++;
    if (ctrl_reg !== ctrl_m) begin fails++; $display("FAIL ro_write_ctrl: got %h, required %h", ctrl_reg, ctrl_m); end
  endtask

  task automatic test_concurrent();
    wr_res_t w;
    rd_res_t r;
    logic [31:0] exp;
    exp = exp_read(6'h00);
    fork
      axi_write(6'h00, 32'h7777_0000, 4'hF, 0, 0, w);
      axi_read(6'h00, 0, 0, r);
    join
    model_write(6'h00, 32'h7777_0000, 4'hF);
    tests++;
    if (r.data !== exp || w.lat !== 1) begin
      fails++; $display("FAIL concurrent: read %h lat %0d, required %h/1", r.data, w.lat, exp);
    end
  endtask

  task automatic test_reset_abort();
    int base;
    bit bv_seen = 0;
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_WDATA = 32'h0000_0001; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    tests++;
    if (bus.S_AXI_RVALID !== 1'b1) begin fails++; $display("FAIL abort_setup: rvalid %b, required 1", bus.S_AXI_RVALID); end
    base = tx_cnt;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 3'b000) begin
      fails++; $display("FAIL abort_drop: rv/bv/awready %b, required 000",
                        {bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ctrl_m = '0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.S_AXI_BVALID !== 1'b0) bv_seen = 1;
    end
    tests++;
    if (bv_seen || ctrl_reg !== 32'h0 || tx_cnt !== base) begin
      fails++; $display("FAIL abort_after: bvalid_seen %0d ctrl %h pulses %0d, required 0/0/0",
                        bv_seen, ctrl_reg, tx_cnt - base);
    end
  endtask

  task automatic test_random();
    wr_res_t w;
    rd_res_t r;
    logic [5:0] addr;
    logic [31:0] data, exp;
    logic [3:0] strb;
    tx_exp = 0;
    tx_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tx_done = 1'($urandom); rd_done = 1'($urandom); wr_done = 1'($urandom);
      processing_done = 1'($urandom);
      total_cycles = $urandom; rd_cycles = $urandom; pr_cycles = $urandom; wr_cycles = $urandom;
      addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 4'($urandom);
        axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), w);
        model_write(addr, data, strb);
        tests++;
        if (w.lat !== 1 || w.resp !== 2'b00 || w.b_after !== 1'b0) begin
          fails++; $display("FAIL rand_write_%0d: lat %0d resp %b b_after %b, required 1/00/0",
                            i, w.lat, w.resp, w.b_after);
        end
      end else begin
        exp = exp_read(addr);
        axi_read(addr, $urandom_range(0, 2), 0, r);
        tests++;
        if (!r.ok || r.data !== exp || r.resp !== 2'b00) begin
          fails++; $display("FAIL rand_read_%0d addr %h: got %h, required %h", i, addr, r.data, exp);
        end
      end
    end
    @(posedge clk); #1;
    tests++;
    if (tx_cnt !== tx_exp || ctrl_reg !== ctrl_m) begin
      fails++; $display("FAIL rand_final: pulses %0d ctrl %h, required %0d/%h", tx_cnt, ctrl_reg, tx_exp, ctrl_m);
    end
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_write_read();
    test_tx_req();
    test_aw_before_w();
    test_status_regs();
    test_read_stall();
    test_ro_write();
    test_concurrent();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tabla_axi_ctrl_slave.md
# tabla_axi_ctrl_slave

AXI4-Lite slave register block through which the host starts Tabla and polls its status and performance counters. It sits between the host AXI-Lite port and the Tabla top level. On the datapath side it drives a start pulse and a control word, and it exposes the done flags and the four cycle counters as read-only registers. It is the responder for the testbench AXI-Lite master driver.

## Interface
- AXIS_DATA_WIDTH, 32: data bus width; only 32 is supported.
- AXIS_ADDR_WIDTH, 6: byte address width, giving 16 word registers.
- PERF_CNTR_WIDTH, 32: counter input width; must be ≤ AXIS_DATA_WIDTH, zero-extended on read.
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESET in 1: asynchronous, active-high reset.
- S_AXI_AWADDR in AXIS_ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write-address channel.
- S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write-data channel.
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write-response channel.
- S_AXI_ARADDR in AXIS_ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read-address channel.
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read-data channel.
- tx_req out 1: one-cycle start pulse to Tabla.
- ctrl_reg out 32: current value of register 0.
- tx_done, rd_done, wr_done, processing_done in 1 each: status flags.
- total_cycles, rd_cycles, pr_cycles, wr_cycles in PERF_CNTR_WIDTH each: performance counters.

## Operation
- Word index = ADDR[AXIS_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
- Register map:
  - 0: CTRL, read/write, byte strobes honoured.
  - 1: tx_done in bit 0. 2: rd_done. 3: wr_done. 4: total_cycles. 5: rd_cycles. 6: pr_cycles. 7: wr_cycles. 8: processing_done. All read-only.
  - 15: ID constant 0x7AB1_A001.
  - Other indices read 0.
- Writes to read-only or unmapped indices are dropped. BRESP and RRESP are always OKAY (2'b00).
- Flag registers read as {31'b0, flag}.
- Write path: AW and W are captured independently into one-entry holding registers (aw_full, w_full).
  - The write executes in the cycle where both are full and BVALID=0. That cycle clears both holding registers and sets BVALID.
  - AWREADY = ~aw_full & ~BVALID & ~rst_hold. WREADY = ~w_full & ~BVALID & ~rst_hold.
- tx_req pulses high for exactly one cycle, the cycle after a CTRL write with WSTRB[0]=1 and WDATA[0]=1. CTRL keeps the written value; it is not self-clearing.
- Read path: ARREADY = ~RVALID & ~rst_hold.
  - On AR handshake, RDATA is loaded from live register/input values and RVALID is set.
  - RDATA and RVALID are held stable until RREADY.
- Write and read to the same index in the same cycle: the read returns the pre-write value.

## Timing
- Reset: CTRL=0, tx_req=0, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=0, aw_full=w_full=0.
- rst_hold=1 during reset and is cleared at the first rising edge after reset deasserts. All READY outputs are therefore 0 during reset and for that first edge.
- Reset mid-transaction aborts everything: pending BVALID/RVALID drop immediately, holding registers clear, no tx_req.
- Write latency: AW and W handshaken at the same edge k → CTRL updated at edge k+1, BVALID high after edge k+1, tx_req high for the cycle after edge k+1. If one channel arrives later, count from the later handshake.
- BVALID clears at the edge where BREADY=1. The next AW/W can be accepted at the following edge.
- Read latency: AR handshake at edge k → RVALID and RDATA valid after edge k. RVALID clears at the edge with RREADY=1. Throughput is one read per 2 cycles with RREADY tied high.
- Read and write channels are independent and may complete concurrently.

## Structure
- Shared package tabla_axi_pkg holds:
  - register index constants (REG_CTRL … REG_ID);
  - ID value;
  - RESP_OKAY.
- Single flat module, no sub-modules. Write channel and read channel are two separate always blocks.

## Test plan
- Reset held 5 cycles, then released: all outputs at their reset values, READYs low during reset, AWREADY/WREADY/ARREADY=1 one cycle after release.
- Write 0xDEADBEEF to byte address 0x00, then read 0x00 → RDATA=0xDEADBEEF; BVALID held until BREADY is raised 3 cycles late.
- Write 0x00000001 to 0x00 → exactly one tx_req pulse one cycle after BVALID-set edge. Write with WSTRB=4'b1110 → CTRL[7:0] unchanged, no tx_req.
- AW presented 4 cycles before W → no BVALID until W handshake; BVALID one edge after it.
- tx_done=1, total_cycles=0x12345678; read 0x04 → 0x00000001, read 0x10 → 0x12345678; read 0x3C → 0x7AB1A001; read 0x28 → 0.
- RREADY low for 5 cycles → RDATA stable while total_cycles changes. Write 0x55 to 0x10 → OKAY, and a subsequent read returns the counter, not 0x55.
